// File: rtl/beat_acc_pkg.sv
// Shared definitions for the beat accumulator: default sizes, FSM state type
// and the sum-width helper.
package beat_acc_pkg;

    localparam int unsigned DATA_W_DEF = 3;
    localparam int unsigned BEATS_DEF  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Wide enough that BEATS all-ones beats cannot overflow.
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned beats);
        return data_w + $clog2(beats);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Mod-BEATS beat counter for the accumulator.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc         count one accepted beat (wraps to 0 after BEATS-1)
//   clr         force count to 0 (takes priority over inc)
//   cnt         current count (registered)
//   last_c      cnt == BEATS-1 (combinational)
module beat_counter
    import beat_acc_pkg::*;
#(
    parameter  int unsigned BEATS = BEATS_DEF,
    localparam int unsigned CNT_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_c = (cnt_q == CNT_W'(BEATS - 1));
    assign cnt    = cnt_q;

    // Next count; explicit wrap so non-power-of-two BEATS works.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beat_accumulator.sv
// Sums groups of BEATS consecutive input beats and presents one registered
// sum per group on a valid/ready output, with backpressure on both sides.
// Optional macro BEAT_ACC_BYPASS_READY_EN: while a sum is held, s_ready follows
// m_ready so the first beat of the next group can be taken in the same cycle
// as the output handshake (zero-bubble streaming).
// Ports:
//   sys_clk, sys_rst_n  clock, async active-low reset
//   s_valid, s_data     upstream beat
//   s_ready             combinational accept indication
//   m_valid, m_data     registered group sum
//   m_ready             downstream accepts the sum
//   grp_cnt             beats accepted in the current group (debug)
module beat_accumulator
    import beat_acc_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned BEATS  = BEATS_DEF,
    localparam int unsigned SUM_W  = sum_w(DATA_W, BEATS),
    localparam int unsigned CNT_W  = $clog2(BEATS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [SUM_W-1:0]  m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  grp_cnt
);

    acc_state_e       state_q;
    acc_state_e       state_d;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_d;
    logic             m_valid_q;
    logic             m_valid_d;
    logic [SUM_W-1:0] m_data_q;
    logic [SUM_W-1:0] m_data_d;
    logic             s_ready_c;
    logic             beat_acc_c;
    logic             cnt_last_c;
    logic [SUM_W-1:0] beat_ext_c;

    assign beat_acc_c = s_valid && s_ready_c;
    assign beat_ext_c = SUM_W'(s_data);

    // Group position; wraps to 0 on the last beat so HOLD always sees 0.
    beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .inc    (beat_acc_c),
        .clr    (1'b0),
        .cnt    (grp_cnt),
        .last_c (cnt_last_c)
    );

    // Next-state, accumulator and output-register logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_ready_c = 1'b0;
        case (state_q)
            ACCUM: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    if (cnt_last_c) begin
                        m_data_d  = acc_q + beat_ext_c;
                        m_valid_d = 1'b1;
                        acc_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        acc_d = acc_q + beat_ext_c;
                    end
                end
            end
            HOLD: begin
`ifdef BEAT_ACC_BYPASS_READY_EN
                s_ready_c = m_ready;
`else
                s_ready_c = 1'b0;
`endif
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ACCUM;
`ifdef BEAT_ACC_BYPASS_READY_EN
                    // Beat taken alongside the handshake opens the next group.
                    if (s_valid) begin
                        acc_d = beat_ext_c;
                    end
`endif
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready = s_ready_c;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule
